// File: rtl/dlx_pkg.sv
// Shared DLX definitions: ROM geometry, reset PC, NOP encoding and the
// instruction-fetch state encoding.
package dlx_pkg;

  localparam int DLX_ROM_ADDR_W = 6;
  localparam int DLX_INST_W     = 32;
  localparam int DLX_RESET_PC   = 0;

  // Presented on the decode bus whenever no valid instruction is held.
  localparam logic [31:0] DLX_NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/dlx_fetch_ctrl_if.sv
// Fetch-to-decode instruction handshake. The fetch side drives the
// instruction, its word address and valid; decode drives ready.
interface dlx_fetch_ctrl_if
  import dlx_pkg::*;
#(
  parameter int ADDR_W = DLX_ROM_ADDR_W,
  parameter int DATA_W = DLX_INST_W
) ();

  logic [DATA_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_pc_o;
  logic              inst_valid_o;
  logic              inst_ready_i;

  modport master (
    output inst_o,
    output inst_pc_o,
    output inst_valid_o,
    input  inst_ready_i
  );

  modport slave (
    input  inst_o,
    input  inst_pc_o,
    input  inst_valid_o,
    output inst_ready_i
  );

endinterface

// File: rtl/dlx_fetch_buf.sv
// Circular prefetch FIFO holding instruction words tagged with their PC.
// Push and pop may coincide even when full; flush empties it at once.
// The head is shown combinationally so it is visible the cycle it lands.
module dlx_fetch_buf
  import dlx_pkg::*;
#(
  parameter  int DEPTH  = 2,
  parameter  int DATA_W = DLX_INST_W,
  parameter  int ADDR_W = DLX_ROM_ADDR_W,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic [ADDR_W-1:0] push_pc_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_data_o,
  output logic [ADDR_W-1:0] head_pc_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [DATA_W-1:0] r_data_mem [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign w_push = push_i && !flush_i;
  assign w_pop  = pop_i && !flush_i && (r_count != '0);

  // Storage write; entries need no reset since the head is masked when empty.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= push_data_i;
      r_pc_mem[r_wr_ptr]   <= push_pc_i;
    end
  end

  // Pointer and occupancy bookkeeping; power-of-two depth wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign valid_o     = (r_count != '0);
  assign count_o     = r_count;
  assign head_data_o = valid_o ? r_data_mem[r_rd_ptr] : DATA_W'(DLX_NOP);
  assign head_pc_o   = valid_o ? r_pc_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/dlx_fetch_ctrl.sv
// DLX instruction-fetch sequencer: owns the PC, drives the ROM address,
// captures ROM words into the prefetch FIFO and serves decode. Redirects
// flush everything; halt stops new issues while letting the buffer drain.
// Optional macro FETCH_PERF_EN adds saturating fetch/bubble counters.
module dlx_fetch_ctrl
  import dlx_pkg::*;
#(
  parameter int ADDR_W    = DLX_ROM_ADDR_W,
  parameter int DATA_W    = DLX_INST_W,
  parameter int BUF_DEPTH = 2,
  parameter int RESET_PC  = DLX_RESET_PC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  output logic [31:0]         rom_addr_o,
  input  logic [DATA_W-1:0]   rom_data_i,
  dlx_fetch_ctrl_if.master    dec_if,
  input  logic                redirect_i,
  input  logic [ADDR_W-1:0]   redirect_pc_i,
  input  logic                halt_i,
  output logic                busy_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]         perf_fetch_o,
  output logic [31:0]         perf_bubble_o
`endif
);

  localparam int               CNT_W      = $clog2(BUF_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] RESET_PC_L = ADDR_W'(RESET_PC);

  fetch_state_e      r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_inflight;

  logic [CNT_W-1:0]  w_count;
  logic              w_buf_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_issue;
  logic [CNT_W:0]    w_occ;
  logic [CNT_W:0]    w_lim;

  // A redirect discards both the pending pop and the returning word.
  assign w_pop  = w_buf_valid && dec_if.inst_ready_i && !redirect_i;
  assign w_push = r_inflight && !redirect_i;

  // Issue only if the slot is guaranteed: count + inflight - pop < depth,
  // rearranged to avoid a subtraction.
  assign w_occ   = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
  assign w_lim   = (CNT_W + 1)'(BUF_DEPTH) + {{CNT_W{1'b0}}, w_pop};
  assign w_issue = (r_state == ST_FETCH) && !halt_i && !redirect_i && (w_occ < w_lim);

  // Fetch FSM with PC, ROM address and in-flight flag as registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC_L;
      r_rom_addr <= RESET_PC_L;
      r_inflight <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE:  r_state <= ST_FETCH;
        ST_FETCH: if (halt_i) r_state <= ST_HALT;
        // A redirect while halted only retargets the PC; it never resumes.
        ST_HALT:  if (!halt_i && !redirect_i) r_state <= ST_FETCH;
        default:  r_state <= ST_IDLE;
      endcase
      // w_issue is already low during a redirect, so this also drops the in-flight word.
      r_inflight <= w_issue;
      if (redirect_i) begin
        r_pc <= redirect_pc_i;
      end else if (w_issue) begin
        r_rom_addr <= r_pc;
        r_pc       <= r_pc + ADDR_W'(1);
      end
    end
  end

  // The ROM address register is held since issue, so it doubles as the capture tag.
  dlx_fetch_buf #(
    .DEPTH  (BUF_DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (redirect_i),
    .push_i      (w_push),
    .push_data_i (rom_data_i),
    .push_pc_i   (r_rom_addr),
    .pop_i       (w_pop),
    .head_data_o (dec_if.inst_o),
    .head_pc_o   (dec_if.inst_pc_o),
    .valid_o     (w_buf_valid),
    .count_o     (w_count)
  );

  assign dec_if.inst_valid_o = w_buf_valid;
  assign rom_addr_o          = {{(32 - ADDR_W){1'b0}}, r_rom_addr};
  assign busy_o              = r_inflight || (w_count != '0);

`ifdef FETCH_PERF_EN
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_bubble;

  // Saturating counters of issued fetches and of decode-ready-but-empty cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf_fetch  <= '0;
      r_perf_bubble <= '0;
    end else begin
      if (w_issue && (r_perf_fetch != 32'hFFFF_FFFF))
        r_perf_fetch <= r_perf_fetch + 32'd1;
      if (dec_if.inst_ready_i && !w_buf_valid && (r_perf_bubble != 32'hFFFF_FFFF))
        r_perf_bubble <= r_perf_bubble + 32'd1;
    end
  end

  assign perf_fetch_o  = r_perf_fetch;
  assign perf_bubble_o = r_perf_bubble;
`endif

endmodule
